// File: rtl/ddr_wr_burst_seq.sv
// Write-burst sequencer for one DDR3 byte lane (clk_div domain).
// Produces DQ/DQS serializer nibbles for preamble, data beats, postamble and seamless bursts.
module ddr_wr_burst_seq #(
    parameter int DQ_WIDTH  = 8,
    parameter int LEN_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  ready,
    input  logic [4*DQ_WIDTH-1:0] wdata,
    output logic                  data_rd,
    output logic [4*DQ_WIDTH-1:0] dq_din,
    output logic [3:0]            dq_tin,
    output logic [3:0]            dqs_din,
    output logic [3:0]            dqs_tin,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        POST = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [4*DQ_WIDTH-1:0]   dq_din_q, dq_din_d;
    logic [3:0]              dq_tin_q, dq_tin_d;
    logic [3:0]              dqs_din_q, dqs_din_d;
    logic [3:0]              dqs_tin_q, dqs_tin_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        data_rd   = 1'b0;
        accept    = start && (len != '0);

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (accept) begin
                    state_d = PRE;
                    cnt_d   = len;
                end
            end
            PRE: begin
                data_rd = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                if (cnt_q > LEN_WIDTH'(1)) begin
                    data_rd = 1'b1;
                    cnt_d   = cnt_q - LEN_WIDTH'(1);
                end else begin
                    // Last beat: a new request here continues DQS toggling without a gap.
                    ready = 1'b1;
                    if (accept) begin
                        data_rd = 1'b1;
                        cnt_d   = len;
                    end else begin
                        state_d = POST;
                        cnt_d   = '0;
                    end
                end
            end
            POST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        dq_din_d  = '0;
        dq_tin_d  = 4'b1111;
        dqs_din_d = 4'b0000;
        dqs_tin_d = 4'b0000;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == POST);
        case (state_d)
            IDLE: dqs_tin_d = 4'b1111;
            DATA: begin
                dq_din_d  = wdata;
                dq_tin_d  = 4'b0000;
                dqs_din_d = 4'b0101;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dq_din_q  <= '0;
            dq_tin_q  <= 4'b1111;
            dqs_din_q <= 4'b0000;
            dqs_tin_q <= 4'b1111;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dq_din_q  <= dq_din_d;
            dq_tin_q  <= dq_tin_d;
            dqs_din_q <= dqs_din_d;
            dqs_tin_q <= dqs_tin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dq_din  = dq_din_q;
    assign dq_tin  = dq_tin_q;
    assign dqs_din = dqs_din_q;
    assign dqs_tin = dqs_tin_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ddr_wr_burst_seq.sv
// Bench for ddr_wr_burst_seq: directed vector table, async-reset sequence and
// random traffic checked against a schedule-of-beats reference model.
module tb_ddr_wr_burst_seq;

    localparam int DQW = 8;
    localparam int LW  = 4;
    localparam int WW  = 4 * DQW;

    localparam int K_IDLE = 0;
    localparam int K_PRE  = 1;
    localparam int K_DATA = 2;
    localparam int K_POST = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          ready;
    logic [WW-1:0] wdata;
    logic          data_rd;
    logic [WW-1:0] dq_din;
    logic [3:0]    dq_tin;
    logic [3:0]    dqs_din;
    logic [3:0]    dqs_tin;
    logic          busy;
    logic          done;

    ddr_wr_burst_seq #(.DQ_WIDTH(DQW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .ready(ready),
        .wdata(wdata), .data_rd(data_rd), .dq_din(dq_din), .dq_tin(dq_tin),
        .dqs_din(dqs_din), .dqs_tin(dqs_tin), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a list of what the coming cycles will be, plus the current cycle.
    int            sched[$];
    int            cur;
    logic [WW-1:0] cur_word;
    logic          exp_ready;
    logic          exp_rd;

    typedef struct {
        logic          st;
        logic [LW-1:0] ln;
        logic [WW-1:0] wd;
        logic          rdy;
        logic          rd;
        logic          bsy;
        logic          dn;
        logic [3:0]    s_tin;
        logic [3:0]    s_din;
        logic [3:0]    d_tin;
        logic [WW-1:0] d_din;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic st, input logic [LW-1:0] ln, input logic [WW-1:0] wd,
                                input logic rdy, input logic rd, input logic bsy, input logic dn,
                                input logic [3:0] s_tin, input logic [3:0] s_din,
                                input logic [3:0] d_tin, input logic [WW-1:0] d_din);
        vec_t v;
        v.st = st; v.ln = ln; v.wd = wd; v.rdy = rdy; v.rd = rd; v.bsy = bsy; v.dn = dn;
        v.s_tin = s_tin; v.s_din = s_din; v.d_tin = d_tin; v.d_din = d_din;
        return v;
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        exp_ready = (cur == K_IDLE) ||
                    (cur == K_DATA && sched.size() == 1 && sched[0] == K_POST);
        if (exp_ready && start && len != '0) begin
            sched.delete();
            if (cur == K_IDLE) sched.push_back(K_PRE);
            for (int i = 0; i < int'(len); i++) sched.push_back(K_DATA);
            sched.push_back(K_POST);
        end
        // A word is fetched exactly one cycle before the beat that sends it.
        exp_rd = (sched.size() > 0) && (sched[0] == K_DATA);
        chk("m_ready",   ready,   exp_ready);
        chk("m_data_rd", data_rd, exp_rd);
        chk("m_busy",    busy,    cur != K_IDLE);
        chk("m_done",    done,    cur == K_POST);
        chk("m_dq_tin",  dq_tin,  (cur == K_DATA) ? 4'b0000 : 4'b1111);
        chk("m_dqs_tin", dqs_tin, (cur == K_IDLE) ? 4'b1111 : 4'b0000);
        chk("m_dqs_din", dqs_din, (cur == K_DATA) ? 4'b0101 : 4'b0000);
        chk("m_dq_din",  dq_din,  cur_word);
    endtask

    task automatic apply(input logic st, input logic [LW-1:0] ln, input logic [WW-1:0] wd);
        start = st;
        len   = ln;
        wdata = wd;
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        cur      = (sched.size() > 0) ? sched.pop_front() : K_IDLE;
        cur_word = exp_rd ? wdata : '0;
        #1;
    endtask

    task automatic cycle(input logic st, input logic [LW-1:0] ln, input logic [WW-1:0] wd);
        apply(st, ln, wd);
        tick();
    endtask

    task automatic chk_idle_now(input string tag);
        chk({tag, "_dq_tin"},  dq_tin,  4'b1111);
        chk({tag, "_dqs_tin"}, dqs_tin, 4'b1111);
        chk({tag, "_dqs_din"}, dqs_din, 4'b0000);
        chk({tag, "_dq_din"},  dq_din,  '0);
        chk({tag, "_busy"},    busy,    1'b0);
        chk({tag, "_done"},    done,    1'b0);
        chk({tag, "_ready"},   ready,   1'b1);
        chk({tag, "_data_rd"}, data_rd, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] wa, wb, wc;
        wa = 32'hA5A5_0001;
        wb = 32'h5A5A_0002;
        wc = 32'hC3C3_0003;

        vecs[0]  = mk(1, 2, 0,  1, 0, 0, 0, 4'hF, 4'h0, 4'hF, 0);
        vecs[1]  = mk(1, 7, wa, 0, 1, 1, 0, 4'h0, 4'h0, 4'hF, 0);
        vecs[2]  = mk(1, 5, wb, 0, 1, 1, 0, 4'h0, 4'h5, 4'h0, wa);
        vecs[3]  = mk(0, 0, 0,  1, 0, 1, 0, 4'h0, 4'h5, 4'h0, wb);
        vecs[4]  = mk(0, 0, 0,  0, 0, 1, 1, 4'h0, 4'h0, 4'hF, 0);
        vecs[5]  = mk(0, 0, 0,  1, 0, 0, 0, 4'hF, 4'h0, 4'hF, 0);
        vecs[6]  = mk(1, 2, 0,  1, 0, 0, 0, 4'hF, 4'h0, 4'hF, 0);
        vecs[7]  = mk(0, 0, wa, 0, 1, 1, 0, 4'h0, 4'h0, 4'hF, 0);
        vecs[8]  = mk(0, 0, wb, 0, 1, 1, 0, 4'h0, 4'h5, 4'h0, wa);
        vecs[9]  = mk(1, 1, wc, 1, 1, 1, 0, 4'h0, 4'h5, 4'h0, wb);
        vecs[10] = mk(0, 0, 0,  1, 0, 1, 0, 4'h0, 4'h5, 4'h0, wc);
        vecs[11] = mk(0, 0, 0,  0, 0, 1, 1, 4'h0, 4'h0, 4'hF, 0);
        vecs[12] = mk(0, 0, 0,  1, 0, 0, 0, 4'hF, 4'h0, 4'hF, 0);

        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        wdata    = '0;
        cur      = K_IDLE;
        cur_word = '0;
        exp_rd   = 1'b0;

        #2 rst = 1'b0;
        #2 chk_idle_now("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        repeat (5) cycle(1'b0, LW'($urandom_range(0, 15)), $urandom);
        repeat (3) cycle(1'b1, '0, $urandom);
        chk("len0_busy", busy, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i].st, vecs[i].ln, vecs[i].wd);
            chk($sformatf("v%0d_ready", i),   ready,   vecs[i].rdy);
            chk($sformatf("v%0d_data_rd", i), data_rd, vecs[i].rd);
            chk($sformatf("v%0d_busy", i),    busy,    vecs[i].bsy);
            chk($sformatf("v%0d_done", i),    done,    vecs[i].dn);
            chk($sformatf("v%0d_dqs_tin", i), dqs_tin, vecs[i].s_tin);
            chk($sformatf("v%0d_dqs_din", i), dqs_din, vecs[i].s_din);
            chk($sformatf("v%0d_dq_tin", i),  dq_tin,  vecs[i].d_tin);
            chk($sformatf("v%0d_dq_din", i),  dq_din,  vecs[i].d_din);
            tick();
        end

        // Asynchronous reset in the middle of a data phase.
        cycle(1'b1, 4'd5, $urandom);
        cycle(1'b0, '0, $urandom);
        cycle(1'b0, '0, $urandom);
        chk("pre_rst_busy", busy, 1'b1);
        start = 1'b0;
        #2 rst = 1'b0;
        #1 chk_idle_now("async_rst");
        @(negedge clk);
        rst = 1'b1;
        sched.delete();
        cur      = K_IDLE;
        cur_word = '0;
        exp_rd   = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 4'd1, $urandom);
        repeat (4) cycle(1'b0, '0, $urandom);

        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 2) == 0, LW'($urandom_range(0, 15)), $urandom);
        end
        repeat (20) cycle(1'b0, '0, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
